spi_regbank: RTL and testbench
==============================

# spi_regbank

Parametrised SPI-mode-0 peripheral that exposes a bank of `NUM_REGS` configuration registers to an external SPI controller, with both write and read-back transactions. It sits between the chip's SPI pins and the PWM/output logic; all SPI inputs are oversampled in the `clk` domain, and the register bank is presented as one flat bus. It extends the earlier write-only peripheral with configurable widths and depth, read-back on CIPO, and frame/address error reporting.

## Interface
Parameters:
- `NUM_REGS`, 5: number of registers, 1..2^ADDR_W.
- `ADDR_W`, 7: address field width in bits.
- `DATA_W`, 8: register and data field width in bits.
- `SYNC_STAGES`, 2: synchroniser flops per SPI input, ≥2.

Ports:
- `clk`  in  1  system clock; must be ≥8× SCLK frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock, asynchronous to `clk`, idle low.
- `ncs`  in  1  SPI chip select, active low.
- `copi`  in  1  controller-out data.
- `cipo`  out  1  peripheral-out data.
- `cipo_oe`  out  1  high while `cipo` is driven (read data phase).
- `regs`  out  NUM_REGS*DATA_W  register bank; reg i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe`  out  1  one-clk pulse when a register is committed.
- `wr_addr`  out  ADDR_W  address of the last committed write; valid with `wr_strobe`.
- `frame_err`  out  1  one-clk pulse: frame ended with wrong bit count.
- `addr_err`  out  1  one-clk pulse: complete frame targeted address ≥ NUM_REGS.

## Operation
- Frame is F = 1 + ADDR_W + DATA_W bits, MSB first, sampled on SCLK rising edges: bit 0 = R/W (1 = write, 0 = read), then address, then data.
- `sclk`, `ncs` and `copi` each pass through SYNC_STAGES flops; edges are detected from the last stage against a one-flop delayed copy. The `ncs` sync chain resets to 1; the others reset to 0.
- Synchronised `ncs` falling edge: clear the bit counter, shift register and overflow flag, and start the frame.
- Each SCLK rising edge while `ncs` is low: shift in `copi`. The counter increments, saturating at F. A rising edge that arrives with the counter already at F sets the overflow flag.
- Write frame: on the synchronised `ncs` rising edge, behaviour depends on the frame.
  - Counter == F, no overflow, address < NUM_REGS: load the data field into reg[address], pulse `wr_strobe`, and update `wr_addr`.
  - Counter == F, no overflow, address ≥ NUM_REGS: no write; pulse `addr_err`.
  - Otherwise (short or overlength): no write; pulse `frame_err`.
- Read frame:
  - When the rising edge of the last address bit is detected (counter reaches 1+ADDR_W), latch reg[address] (or 0 if address ≥ NUM_REGS) into the output shifter. Assert `cipo_oe` and drive `cipo` = data MSB.
  - Each subsequent SCLK falling edge shifts the next bit out. After the data LSB's falling edge, `cipo` drives 0.
  - Read frames never modify `regs`. End-of-frame error pulses follow the same rules as writes.
- `ncs` high: `cipo_oe` = 0 and `cipo` = 0; SCLK edges are ignored.

## Timing
- Reset values: `regs` all 0, `cipo` 0, `cipo_oe` 0, `wr_strobe` 0, `wr_addr` 0, `frame_err` 0, `addr_err` 0, counter 0.
- Pin-to-detection latency is SYNC_STAGES+1 clk for any SPI input edge.
- Write commit: `regs` update and `wr_strobe` occur on the same clk edge, SYNC_STAGES+1 clk after the `ncs` pin rises. `wr_strobe`, `frame_err` and `addr_err` are single-cycle and mutually exclusive.
- Read: the `cipo` MSB is valid SYNC_STAGES+2 clk after the last address SCLK rise. Each later bit is valid SYNC_STAGES+2 clk after its SCLK fall. With clk ≥ 8× SCLK, every bit is stable before the controller's sampling rise.
- Simultaneous `ncs` rise and SCLK rise detected in the same clk: the `ncs` rise wins and the SCLK edge is dropped.
- Simultaneous `ncs` fall and SCLK rise in the same clk: the frame starts and the SCLK edge is dropped. Controllers must keep ≥1 SCLK half-period between `ncs` fall and the first rise.
- `rst_n` asserted mid-frame: the frame is aborted with no commit and no error pulse. After release, the block waits for a fresh `ncs` falling edge.
- A back-to-back frame (`ncs` high for ≥ SYNC_STAGES+2 clk) is handled independently of the previous frame.

## Test plan
- Defaults. Write 0xA5 to addr 2 → reg2 = 0xA5, one `wr_strobe`, `wr_addr` = 2; all other regs stay 0.
- Write 0x3C to addr 4, then read addr 4 → `cipo` bits 0,0,1,1,1,1,0,0 during the data phase, `cipo_oe` high only in that phase, regs unchanged.
- Write to addr 5 (NUM_REGS = 5) → `addr_err` pulse, no `wr_strobe`, regs unchanged. Read addr 5 → `cipo` returns 0x00 and `addr_err` pulses.
- Write frame of 15 bits, then one of 17 bits, to addr 0 with data 0xFF → `frame_err` pulse for each, reg0 stays 0.
- Assert `rst_n` mid-frame after reg1 = 0x11 → all regs 0. The next full write of 0x22 to addr 1 gives reg1 = 0x22.
- Instance with DATA_W = 16, ADDR_W = 4, NUM_REGS = 12: write 0xBEEF to addr 11 → `regs[191:176]` = 0xBEEF. A read of addr 11 returns 0xBEEF.

Source files
------------

// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 peripheral exposing NUM_REGS registers of DATA_W bits.
// Every SPI pin is oversampled in the clk domain. A frame carries R/W, then the
// address, then the data, MSB first. Writes commit when chip select rises. Reads
// stream the addressed register back on cipo, one bit per SCLK falling edge.
module spi_regbank #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic                       addr_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int REGS_W  = NUM_REGS * DATA_W;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_W);      // count before the last address bit
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);  // count once the address is complete
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  // Address decode shared by the write-commit and read-latch paths.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS));
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic                   sclk_dly_q,  sclk_dly_d;
  logic                   ncs_dly_q,   ncs_dly_d;
  logic                   in_frame_q,  in_frame_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [FRAME_W-1:0]     shift_q,     shift_d;
  logic                   ovf_q,       ovf_d;
  logic                   rd_phase_q,  rd_phase_d;
  logic [DATA_W-1:0]      rd_shift_q,  rd_shift_d;
  logic [REGS_W-1:0]      regs_q,      regs_d;
  logic                   cipo_q,      cipo_d;
  logic                   cipo_oe_q,   cipo_oe_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]      wr_addr_q,   wr_addr_d;
  logic                   frame_err_q, frame_err_d;
  logic                   addr_err_q,  addr_err_d;

  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;
  logic                   sclk_act_s;
  logic [FRAME_W-1:0]     shift_nxt_s;
  logic [ADDR_W-1:0]      rd_addr_s;
  logic                   rd_rw_s;
  logic [DATA_W-1:0]      rd_data_s;
  logic                   fr_rw_s;
  logic [ADDR_W-1:0]      fr_addr_s;
  logic [DATA_W-1:0]      fr_data_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  assign sclk_rise_s = sclk_s & ~sclk_dly_q;
  assign sclk_fall_s = ~sclk_s & sclk_dly_q;
  assign ncs_rise_s  = ncs_s & ~ncs_dly_q;
  assign ncs_fall_s  = ~ncs_s & ncs_dly_q;

  // SCLK edges count only inside a frame. A chip-select edge seen in the same
  // clk takes priority and drops the SCLK edge.
  assign sclk_act_s = in_frame_q & ~ncs_rise_s & ~ncs_fall_s;

  // Shift-register contents if the current COPI bit is accepted. While the last
  // address bit arrives, the low bits hold the R/W flag and the full address.
  assign shift_nxt_s = {shift_q[FRAME_W-2:0], copi_s};
  assign rd_addr_s   = shift_nxt_s[ADDR_W-1:0];
  assign rd_rw_s     = shift_nxt_s[ADDR_W];

  // Fields of a completed frame, used when chip select rises.
  assign fr_rw_s   = shift_q[FRAME_W-1];
  assign fr_addr_s = shift_q[DATA_W +: ADDR_W];
  assign fr_data_s = shift_q[DATA_W-1:0];

  // Read-back mux. An out-of-range address reads as zero.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_s == ADDR_W'(i)) begin
        rd_data_s = regs_q[i*DATA_W +: DATA_W];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // Next-state logic: synchronisers, frame tracking, commit/error decode and the read shifter.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    sclk_dly_d  = sclk_s;
    ncs_dly_d   = ncs_s;
    in_frame_d  = in_frame_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ovf_d       = ovf_q;
    rd_phase_d  = rd_phase_q;
    rd_shift_d  = rd_shift_q;
    regs_d      = regs_q;
    wr_addr_d   = wr_addr_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    // cipo/cipo_oe follow the read shifter one clk later, so each bit appears
    // SYNC_STAGES+2 clk after the SCLK edge that produced it.
    cipo_d      = rd_phase_q & rd_shift_q[DATA_W-1];
    cipo_oe_d   = rd_phase_q;

    if (ncs_fall_s) begin
      in_frame_d = 1'b1;
      cnt_d      = {CNT_W{1'b0}};
      shift_d    = {FRAME_W{1'b0}};
      ovf_d      = 1'b0;
      rd_phase_d = 1'b0;
      rd_shift_d = {DATA_W{1'b0}};
    end else if (ncs_rise_s) begin
      in_frame_d = 1'b0;
      rd_phase_d = 1'b0;
      if (in_frame_q && (cnt_q == CNT_FULL) && !ovf_q) begin
        if (addr_in_range(fr_addr_s)) begin
          if (fr_rw_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (fr_addr_s == ADDR_W'(i)) begin
                regs_d[i*DATA_W +: DATA_W] = fr_data_s;
              end else begin
                regs_d[i*DATA_W +: DATA_W] = regs_q[i*DATA_W +: DATA_W];
              end
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = fr_addr_s;
          end else begin
            // A well-formed read completes silently.
            wr_strobe_d = 1'b0;
          end
        end else begin
          addr_err_d = 1'b1;
        end
      end else if (in_frame_q) begin
        frame_err_d = 1'b1;
      end else begin
        // A chip-select rise outside a frame (e.g. after reset) carries no data.
        frame_err_d = 1'b0;
      end
    end else if (sclk_act_s && sclk_rise_s) begin
      if (cnt_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
        shift_d = shift_nxt_s;
        if ((cnt_q == CNT_LAST) && !rd_rw_s) begin
          rd_phase_d = 1'b1;
          rd_shift_d = rd_data_s;
        end else begin
          rd_phase_d = rd_phase_q;
        end
      end
    end else if (sclk_act_s && sclk_fall_s) begin
      // The fall right after the last address bit keeps the MSB on the line.
      // Only falls after a data-bit rise advance the read shifter.
      if (rd_phase_q && (cnt_q > CNT_ADDR)) begin
        rd_shift_d = rd_shift_q << 1;
      end else begin
        rd_shift_d = rd_shift_q;
      end
    end else begin
      in_frame_d = in_frame_q;
    end
  end

  // State and output registers; asynchronous reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      ncs_sync_q  <= {SYNC_STAGES{1'b1}};
      copi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      in_frame_q  <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      shift_q     <= {FRAME_W{1'b0}};
      ovf_q       <= 1'b0;
      rd_phase_q  <= 1'b0;
      rd_shift_q  <= {DATA_W{1'b0}};
      regs_q      <= {REGS_W{1'b0}};
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      copi_sync_q <= copi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ncs_dly_q   <= ncs_dly_d;
      in_frame_q  <= in_frame_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ovf_q       <= ovf_d;
      rd_phase_q  <= rd_phase_d;
      rd_shift_q  <= rd_shift_d;
      regs_q      <= regs_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign regs      = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Testbench for spi_regbank: a default instance (5 x 8-bit, 7-bit address) and a
// wide instance (12 x 16-bit, 4-bit address). Frames come from a vector table.
// End-of-frame pulses are checked against a scoreboard queue.
module tb_spi_regbank;

  localparam int K_NONE   = 0;
  localparam int K_STROBE = 1;
  localparam int K_AERR   = 2;
  localparam int K_FERR   = 3;

  typedef struct {
    int          inst;
    int          nbits;
    logic [31:0] word;
    int          kind;
    int          addr;
    logic [15:0] rdata;
    bit          chk_rd;
    logic [31:0] exp_oe;
  } vec_t;

  typedef struct {
    int inst;
    int kind;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic         sclk0, ncs0, copi0, cipo0, oe0, strb0, ferr0, aerr0;
  logic [39:0]  regs0;
  logic [6:0]   waddr0;
  logic         sclk1, ncs1, copi1, cipo1, oe1, strb1, ferr1, aerr1;
  logic [191:0] regs1;
  logic [3:0]   waddr1;

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  vec_t        tbl[$];
  logic [7:0]  m0[5];
  logic [15:0] m1[12];

  always #5 clk = ~clk;

  spi_regbank u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk0), .ncs(ncs0), .copi(copi0),
    .cipo(cipo0), .cipo_oe(oe0), .regs(regs0), .wr_strobe(strb0),
    .wr_addr(waddr0), .frame_err(ferr0), .addr_err(aerr0)
  );

  spi_regbank #(.NUM_REGS(12), .ADDR_W(4), .DATA_W(16), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk1), .ncs(ncs1), .copi(copi1),
    .cipo(cipo1), .cipo_oe(oe1), .regs(regs1), .wr_strobe(strb1),
    .wr_addr(waddr1), .frame_err(ferr1), .addr_err(aerr1)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv_sclk(input int w, input logic v);
    if (w == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic drv_ncs(input int w, input logic v);
    if (w == 0) ncs0 = v; else ncs1 = v;
  endtask

  task automatic drv_copi(input int w, input logic v);
    if (w == 0) copi0 = v; else copi1 = v;
  endtask

  // Controller side of one frame: SCLK half-period of 8 clk; cipo/cipo_oe are
  // captured just before each SCLK rise, where a mode-0 controller samples.
  task automatic run_frame(input int w, input int nbits, input logic [31:0] word,
                           output logic [31:0] cap, output logic [31:0] oec);
    cap = 32'h0;
    oec = 32'h0;
    drv_ncs(w, 1'b0);
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      drv_copi(w, word[nbits-1-i]);
      wait_clk(8);
      cap = {cap[30:0], (w == 0) ? cipo0 : cipo1};
      oec = {oec[30:0], (w == 0) ? oe0 : oe1};
      drv_sclk(w, 1'b1);
      wait_clk(8);
      drv_sclk(w, 1'b0);
    end
    wait_clk(8);
    drv_ncs(w, 1'b1);
    drv_copi(w, 1'b0);
  endtask

  task automatic check_regs(input string nm);
    logic [39:0]  e0;
    logic [191:0] e1;
    for (int i = 0; i < 5; i++)  e0[i*8 +: 8]   = m0[i];
    for (int i = 0; i < 12; i++) e1[i*16 +: 16] = m1[i];
    chk({nm, "_regs0"}, 256'(regs0), 256'(e0));
    chk({nm, "_regs1"}, 256'(regs1), 256'(e1));
  endtask

  // Scoreboard side: each end-of-frame pulse pops the oldest expectation.
  task automatic mon(input int w, input logic s, input logic a, input logic f, input int wa);
    int   kind;
    exp_t e;
    if (s | a | f) begin
      kind = s ? K_STROBE : (a ? K_AERR : K_FERR);
      chk("pulse_onehot", 256'(32'(s) + 32'(a) + 32'(f)), 256'(1));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: inst %0d got kind %0d, expected no pulse", w, kind);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_inst", 256'(w), 256'(e.inst));
        chk("pulse_kind", 256'(kind), 256'(e.kind));
        if (kind == K_STROBE) chk("wr_addr", 256'(wa), 256'(e.addr));
      end
    end
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] cap, oec, mask;
    mask = (v.inst == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    if (v.kind != K_NONE) exp_q.push_back('{v.inst, v.kind, v.addr});
    if (v.kind == K_STROBE) begin
      if (v.inst == 0) m0[v.addr] = v.word[7:0];
      else             m1[v.addr] = v.word[15:0];
    end
    run_frame(v.inst, v.nbits, v.word, cap, oec);
    wait_clk(12);
    chk("pulse_pending", 256'(exp_q.size()), 256'(0));
    if (exp_q.size() != 0) exp_q.delete();
    check_regs("frame");
    chk("oe_in_frame", 256'(oec), 256'(v.exp_oe));
    if (v.chk_rd) chk("read_data", 256'(cap & mask), 256'(v.rdata));
    if (v.inst == 0) chk("idle_cipo0", 256'({cipo0, oe0}), 256'(0));
    else             chk("idle_cipo1", 256'({cipo1, oe1}), 256'(0));
  endtask

  initial begin
    logic [31:0] w;

    rst_n = 1'b0;
    sclk0 = 1'b0; ncs0 = 1'b1; copi0 = 1'b0;
    sclk1 = 1'b0; ncs1 = 1'b1; copi1 = 1'b0;
    for (int i = 0; i < 5; i++)  m0[i] = 8'h00;
    for (int i = 0; i < 12; i++) m1[i] = 16'h0000;

    // inst, nbits, word, kind, addr, rdata, chk_rd, exp_oe
    tbl.push_back('{0, 16, 32'h0000_82A5, K_STROBE, 2, 16'h0000, 1'b0, 32'h0});   // wr 0xA5 -> 2
    tbl.push_back('{0, 16, 32'h0000_843C, K_STROBE, 4, 16'h0000, 1'b0, 32'h0});   // wr 0x3C -> 4
    tbl.push_back('{0, 16, 32'h0000_0400, K_NONE,   0, 16'h003C, 1'b1, 32'hFF});  // rd 4
    tbl.push_back('{0, 16, 32'h0000_8577, K_AERR,   5, 16'h0000, 1'b0, 32'h0});   // wr addr 5
    tbl.push_back('{0, 16, 32'h0000_0500, K_AERR,   5, 16'h0000, 1'b1, 32'hFF});  // rd addr 5
    tbl.push_back('{0, 15, 32'h0000_407F, K_FERR,   0, 16'h0000, 1'b0, 32'h0});   // 15-bit frame
    tbl.push_back('{0, 17, 32'h0001_01FF, K_FERR,   0, 16'h0000, 1'b0, 32'h0});   // 17-bit frame
    tbl.push_back('{0, 16, 32'h0000_8111, K_STROBE, 1, 16'h0000, 1'b0, 32'h0});   // wr 0x11 -> 1
    tbl.push_back('{0, 16, 32'h0000_0200, K_NONE,   0, 16'h00A5, 1'b1, 32'hFF});  // rd 2
    tbl.push_back('{1, 21, 32'h001B_BEEF, K_STROBE, 11, 16'h0000, 1'b0, 32'h0});  // wide wr
    tbl.push_back('{1, 21, 32'h000B_0000, K_NONE,   0, 16'hBEEF, 1'b1, 32'hFFFF}); // wide rd

    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(2);

    chk("rst_regs0", 256'(regs0), 256'(0));
    chk("rst_regs1", 256'(regs1), 256'(0));
    chk("rst_cipo", 256'({cipo0, oe0, cipo1, oe1}), 256'(0));
    chk("rst_pulses", 256'({strb0, ferr0, aerr0, strb1, ferr1, aerr1}), 256'(0));
    chk("rst_waddr", 256'({waddr0, waddr1}), 256'(0));

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          mon(0, strb0, aerr0, ferr0, 32'(waddr0));
          mon(1, strb1, aerr1, ferr1, 32'(waddr1));
        end
      end
    join_none

    foreach (tbl[i]) apply(tbl[i]);
    chk("wide_reg11_slice", 256'(regs1[191:176]), 256'(16'hBEEF));

    // Reset during a frame: no commit, no pulse, bank cleared.
    w = 32'h0000_8122;
    drv_ncs(0, 1'b0);
    wait_clk(8);
    for (int i = 0; i < 6; i++) begin
      drv_copi(0, w[15-i]);
      wait_clk(8);
      drv_sclk(0, 1'b1);
      wait_clk(8);
      drv_sclk(0, 1'b0);
    end
    rst_n = 1'b0;
    wait_clk(3);
    drv_ncs(0, 1'b1);
    drv_copi(0, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)  m0[i] = 8'h00;
    for (int i = 0; i < 12; i++) m1[i] = 16'h0000;
    wait_clk(12);
    check_regs("after_reset");
    chk("after_reset_pending", 256'(exp_q.size()), 256'(0));

    apply('{0, 16, 32'h0000_8122, K_STROBE, 1, 16'h0000, 1'b0, 32'h0});
    apply('{0, 16, 32'h0000_0100, K_NONE,   0, 16'h0022, 1'b1, 32'hFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
